// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: async assert, synchronized release, stretch, software reset path.
// Optional RST_CAUSE output is enabled by defining RST_SEQ_CAUSE_EN.
module rst_seq_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int SW_HOLD_CYCLES = 4
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       SW_REQ,
  output logic       RN_OUT,
  output logic       RST_DONE,
  output logic       SW_ACK
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0] RST_CAUSE
`endif
);

  typedef enum logic [2:0] {
    ASSERT  = 3'd0,
    SYNC    = 3'd1,
    STRETCH = 3'd2,
    SWRST   = 3'd3,
    RUN     = 3'd4
  } state_e;

  localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_CYCLES - 1);
  localparam logic [7:0] SW_LOAD      = 8'(SW_HOLD_CYCLES - 1);

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic                   rn_out_q;
  logic                   done_q;
  logic                   sw_ack_q;
  logic                   sw_path_q;
  logic                   sw_req_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_rel;
  logic                   sw_rise;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_rel = sync_q[SYNC_STAGES-1];
  assign sw_rise  = SW_REQ & ~sw_req_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // sw_path_q remembers that the current stretch came from a software reset,
  // so only that path produces SW_ACK when RN_OUT rises again.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= ASSERT;
      cnt_q     <= 8'd0;
      rn_out_q  <= 1'b0;
      done_q    <= 1'b0;
      sw_ack_q  <= 1'b0;
      sw_path_q <= 1'b0;
      sw_req_q  <= 1'b0;
    end else begin
      sw_req_q <= SW_REQ;
      sw_ack_q <= 1'b0;
      case (state_q)
        ASSERT, SYNC: begin
          if (sync_rel) begin
            state_q <= STRETCH;
            cnt_q   <= STRETCH_LOAD;
          end else begin
            state_q <= SYNC;
          end
        end
        STRETCH: begin
          if (cnt_q == 8'd0) begin
            state_q   <= RUN;
            rn_out_q  <= 1'b1;
            done_q    <= 1'b1;
            sw_ack_q  <= sw_path_q;
            sw_path_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SWRST: begin
          if (cnt_q == 8'd0) begin
            state_q <= STRETCH;
            cnt_q   <= STRETCH_LOAD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RUN: begin
          if (sw_rise) begin
            state_q   <= SWRST;
            rn_out_q  <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= SW_LOAD;
            sw_path_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ASSERT;
        end
      endcase
    end
  end

  assign RN_OUT   = rn_out_q;
  assign RST_DONE = done_q;
  assign SW_ACK   = sw_ack_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cause_q <= 2'b01;
    end else if (state_q == RUN && sw_rise) begin
      cause_q <= 2'b10;
    end
  end

  assign RST_CAUSE = cause_q;
`endif

endmodule
